spin_sequencer: RTL and testbench
=================================

# spin_sequencer

Game sequencer for the slot machine. It accepts a gamble request, checks the bet against the balance and commands the bet debit. It then runs three reels at the slow game rate and stops them one after another. Finally it scores the result and commands the payout credit. It sits between the debounced/edge-detected buttons, the balance logic, and the reel digit encoders that feed the VGA path.

## Interface
- SPIN_TICKS, 3: ticks from spin start until reel 1 stops (≥1).
- STAGGER, 1: ticks between successive reel stops (≥1); SPIN_TICKS+2*STAGGER ≤ 255.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tick  in  1  one-clk-wide game-rate strobe from the clock divider.
- gamble  in  1  one-clk-wide gamble request (edge-detected).
- cash_out  in  1  one-clk-wide cash-out/abort request.
- balance  in  11  current balance, unsigned.
- bet  in  11  wager (5/10/20 from buffer switches); 0 means no bet.
- rnd  in  9  free-running random source; [2:0] reel 1, [5:3] reel 2, [8:6] reel 3.
- debit  out  1  one-cycle pulse: balance logic subtracts bet.
- credit  out  1  one-cycle pulse: balance logic adds payout.
- payout  out  11  payout value, valid while credit=1, held until next EVAL.
- result  out  2  00 none, 01 pair, 10 triple; held until next EVAL.
- busy  out  1  spin in progress.
- reel_run  out  3  bit i = reel i+1 spinning.
- digit_1, digit_2, digit_3  out  3  current reel symbols (7 = "seven").

## Operation
- States: IDLE, SPIN, EVAL. Reset: IDLE; all outputs 0; tick counter 0.
- IDLE→SPIN when gamble=1 AND cash_out=0 AND credit=0 AND bet≠0 AND balance≥bet. On that edge: debit=1 for one cycle, busy=1, reel_run=111, tick counter=0.
- A request that fails any condition is dropped: no debit, no state change.
- SPIN, on each tick: tick counter increments. Every reel whose reel_run bit is set loads its digit from its rnd slice.
- Reel stops: reel 1 clears its reel_run bit on tick number SPIN_TICKS. Reel 2 clears on tick SPIN_TICKS+STAGGER. Reel 3 clears on tick SPIN_TICKS+2*STAGGER. The digit loaded on a reel's stop tick is its final symbol.
- SPIN→EVAL on the reel 3 stop edge.
- EVAL (one cycle) scores the digits:
  - triple (all three equal): result=10, payout=bet*8.
  - pair (exactly two equal): result=01, payout=bet*2.
  - otherwise: result=00, payout=0.
  - All products saturate at 2047.
- EVAL→IDLE on the next edge, which also registers result and payout. credit=1 for that one cycle if payout≠0. busy=0.
- cash_out in SPIN: abort. Next edge: reel_run=000, busy=0, state IDLE. Digits freeze. No credit; bet stays forfeited; result and payout unchanged.
- cash_out in EVAL: ignored; payout completes.
- gamble in SPIN/EVAL: ignored.
- gamble and cash_out in the same IDLE cycle: cash_out wins, no spin.
- gamble during the credit cycle is ignored, because the balance has not yet settled.
- Reset mid-spin: immediately IDLE, all outputs 0, no debit or credit pulses.

## Timing
- gamble cycle N → debit and busy high in cycle N+1.
- A tick coincident with the accepting edge is not counted.
- The reel_run bit clears on the edge after the qualifying tick cycle.
- Last stop tick in cycle M → EVAL in cycle M+1 → credit, result and payout valid from cycle M+2; busy low from M+2.
- Defaults: the spin lasts 5 ticks, plus 2 clk cycles.
- tick is a clk-domain enable; no internal clock dividing.

## Configuration
- SPIN_JACKPOT_EN defined: triple 7s pays bet*16 (saturating), with result=10.
- Undefined: triple 7s pays bet*8 like any other triple.

## Test plan
- balance=100, bet=10, rnd=9'o555, gamble → debit 1 cycle. After tick 5, busy=0, digits 5/5/5, result=10, payout=80, credit 1 cycle.
- balance=5, bet=10, gamble → debit never asserts, busy stays 0. Repeat with bet=0 → same.
- rnd=9'o777, bet=20 → payout=320 with SPIN_JACKPOT_EN, 160 without.
- rnd changes every tick, ending at 9'o321 → reel_run 111→110→100→000 after ticks 3, 4, 5. result=00, payout=0, credit never asserts.
- cash_out after tick 2 → next cycle reel_run=000, busy=0, no credit, result/payout keep prior values.
- gamble in credit cycle → ignored. gamble+cash_out same IDLE cycle → ignored. rst_n low mid-SPIN → all outputs 0 immediately.

Source files
------------

// File: rtl/spin_sequencer.sv
// Slot-machine spin sequencer: bet debit, staggered reel stops, scoring and payout.
// Optional: define SPIN_JACKPOT_EN so that a triple seven pays bet*16.
module spin_sequencer #(
  parameter int SPIN_TICKS = 3,
  parameter int STAGGER    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        gamble,
  input  logic        cash_out,
  input  logic [10:0] balance,
  input  logic [10:0] bet,
  input  logic [8:0]  rnd,
  output logic        debit,
  output logic        credit,
  output logic [10:0] payout,
  output logic [1:0]  result,
  output logic        busy,
  output logic [2:0]  reel_run,
  output logic [2:0]  digit_1,
  output logic [2:0]  digit_2,
  output logic [2:0]  digit_3
);

  localparam logic [7:0] STOP1 = 8'(SPIN_TICKS);
  localparam logic [7:0] STOP2 = 8'(SPIN_TICKS + STAGGER);
  localparam logic [7:0] STOP3 = 8'(SPIN_TICKS + 2 * STAGGER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPIN,
    S_EVAL
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [2:0]  r_run;
  logic [2:0]  r_d1, r_d2, r_d3;
  logic        r_debit, r_credit, r_busy;
  logic [10:0] r_payout;
  logic [1:0]  r_result;

  logic        w_accept;
  logic [7:0]  w_cnt_inc;
  logic        w_triple, w_pair;
  logic [14:0] w_prod;
  logic [1:0]  w_result;
  logic [10:0] w_payout;

  assign w_cnt_inc = r_cnt + 8'd1;

  // The credit cycle blocks a new spin: balance has not absorbed the payout yet.
  assign w_accept = gamble & ~cash_out & ~r_credit
                  & (bet != 11'd0) & (balance >= bet);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_SPIN;
      S_SPIN: begin
        if (cash_out)
          w_state_nxt = S_IDLE;
        else if (tick && w_cnt_inc == STOP3)
          w_state_nxt = S_EVAL;
      end
      S_EVAL: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_triple = (r_d1 == r_d2) && (r_d2 == r_d3);
  assign w_pair   = !w_triple && ((r_d1 == r_d2) ||
                    (r_d1 == r_d3) || (r_d2 == r_d3));

  always_comb begin
    w_prod   = '0;
    w_result = 2'b00;
    if (w_triple) begin
      w_result = 2'b10;
      w_prod   = {1'b0, bet, 3'b000};
`ifdef SPIN_JACKPOT_EN
      if (r_d1 == 3'd7) w_prod = {bet, 4'b0000};
`endif
    end else if (w_pair) begin
      w_result = 2'b01;
      w_prod   = {3'b000, bet, 1'b0};
    end
    w_payout = (w_prod[14:11] != 4'd0) ? 11'd2047 : w_prod[10:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_run    <= '0;
      r_d1     <= '0;
      r_d2     <= '0;
      r_d3     <= '0;
      r_debit  <= 1'b0;
      r_credit <= 1'b0;
      r_busy   <= 1'b0;
      r_payout <= '0;
      r_result <= '0;
    end else begin
      r_debit  <= 1'b0;
      r_credit <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_debit <= 1'b1;
            r_busy  <= 1'b1;
            r_run   <= 3'b111;
            r_cnt   <= '0;
          end
        end
        S_SPIN: begin
          if (cash_out) begin
            r_run  <= 3'b000;
            r_busy <= 1'b0;
          end else if (tick) begin
            r_cnt <= w_cnt_inc;
            if (r_run[0]) r_d1 <= rnd[2:0];
            if (r_run[1]) r_d2 <= rnd[5:3];
            if (r_run[2]) r_d3 <= rnd[8:6];
            if (w_cnt_inc == STOP1) r_run[0] <= 1'b0;
            if (w_cnt_inc == STOP2) r_run[1] <= 1'b0;
            if (w_cnt_inc == STOP3) r_run[2] <= 1'b0;
          end
        end
        S_EVAL: begin
          r_result <= w_result;
          r_payout <= w_payout;
          r_credit <= (w_payout != 11'd0);
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign debit    = r_debit;
  assign credit   = r_credit;
  assign payout   = r_payout;
  assign result   = r_result;
  assign busy     = r_busy;
  assign reel_run = r_run;
  assign digit_1  = r_d1;
  assign digit_2  = r_d2;
  assign digit_3  = r_d3;

endmodule

// File: tb/tb_spin_sequencer.sv
// Scoreboard bench for spin_sequencer: expected debit and end-of-spin
// events are queued by the stimulus and checked by a negedge monitor.
module tb_spin_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        gamble = 1'b0;
  logic        cash_out = 1'b0;
  logic [10:0] balance = '0;
  logic [10:0] bet = '0;
  logic [8:0]  rnd = '0;
  logic        debit, credit, busy;
  logic [10:0] payout;
  logic [1:0]  result;
  logic [2:0]  reel_run, digit_1, digit_2, digit_3;

`ifdef SPIN_JACKPOT_EN
  localparam logic [10:0] JP = 11'd320;
`else
  localparam logic [10:0] JP = 11'd160;
`endif

  spin_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .gamble(gamble), .cash_out(cash_out),
    .balance(balance), .bet(bet), .rnd(rnd),
    .debit(debit), .credit(credit),
    .payout(payout), .result(result),
    .busy(busy), .reel_run(reel_run),
    .digit_1(digit_1), .digit_2(digit_2),
    .digit_3(digit_3)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          kind;
    bit          cr;
    logic [10:0] pay;
    logic [1:0]  res;
    logic [2:0]  d1, d2, d3;
  } ev_t;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;
  bit  prev_busy = 1'b0;

  task automatic cmp(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               n, act, exp, $time);
    end
  endtask

  task automatic push(bit k, bit c, logic [10:0] p,
                      logic [1:0] r, logic [2:0] a,
                      logic [2:0] b, logic [2:0] e);
    ev_t ev;
    ev.kind = k; ev.cr = c; ev.pay = p; ev.res = r;
    ev.d1 = a; ev.d2 = b; ev.d3 = e;
    q.push_back(ev);
  endtask

  always @(negedge clk) begin
    ev_t ev;
    if (debit) begin
      if (q.size() == 0) begin
        cmp("unexpected_debit", 1, 0);
      end else begin
        ev = q.pop_front();
        cmp("debit_kind", 0, int'(ev.kind));
        cmp("debit_busy", int'(busy), 1);
        cmp("debit_run", int'(reel_run), 7);
      end
    end
    if (prev_busy && !busy) begin
      if (q.size() == 0) begin
        cmp("unexpected_end", 1, 0);
      end else begin
        ev = q.pop_front();
        cmp("end_kind", 1, int'(ev.kind));
        cmp("credit", int'(credit), int'(ev.cr));
        cmp("payout", int'(payout), int'(ev.pay));
        cmp("result", int'(result), int'(ev.res));
        cmp("digit_1", int'(digit_1), int'(ev.d1));
        cmp("digit_2", int'(digit_2), int'(ev.d2));
        cmp("digit_3", int'(digit_3), int'(ev.d3));
        cmp("end_run", int'(reel_run), 0);
      end
    end else if (credit) begin
      cmp("stray_credit", 1, 0);
    end
    prev_busy = busy;
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  task automatic play(logic [10:0] bal, logic [10:0] b,
                      logic [8:0] r, logic [10:0] p,
                      logic [1:0] res, logic [2:0] a,
                      logic [2:0] c, logic [2:0] e);
    balance = bal; bet = b; rnd = r;
    push(0, 0, 0, 0, 0, 0, 0);
    push(1, p != 0, p, res, a, c, e);
    gamble = 1'b1;
    cyc();
    gamble = 1'b0;
    repeat (5) do_tick();
    cyc(3);
  endtask

  initial begin
    cyc(2);
    cmp("rst_debit", int'(debit), 0);
    cmp("rst_credit", int'(credit), 0);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_run", int'(reel_run), 0);
    cmp("rst_payout", int'(payout), 0);
    cmp("rst_result", int'(result), 0);
    rst_n = 1'b1;
    cyc(2);

    // triple 5s, then gamble held in the credit cycle
    balance = 11'd100; bet = 11'd10; rnd = 9'o555;
    push(0, 0, 0, 0, 0, 0, 0);
    push(1, 1, 11'd80, 2'b10, 5, 5, 5);
    gamble = 1'b1;
    cyc();
    gamble = 1'b0;
    repeat (5) do_tick();
    cmp("credit_cycle", int'(credit), 1);
    gamble = 1'b1;
    cyc();
    gamble = 1'b0;
    cyc(3);
    cmp("credit_gamble_busy", int'(busy), 0);

    // insufficient balance and zero bet
    balance = 11'd5; bet = 11'd10;
    gamble = 1'b1; cyc(); gamble = 1'b0; cyc(3);
    cmp("lowbal_busy", int'(busy), 0);
    balance = 11'd100; bet = 11'd0;
    gamble = 1'b1; cyc(); gamble = 1'b0; cyc(3);
    cmp("zerobet_busy", int'(busy), 0);

    play(11'd100, 11'd10, 9'o355, 11'd20, 2'b01, 5, 5, 3);
    play(11'd2000, 11'd300, 9'o111, 11'd2047, 2'b10, 1, 1, 1);
    play(11'd100, 11'd20, 9'o777, JP, 2'b10, 7, 7, 7);

    // abort after two ticks keeps prior result/payout
    balance = 11'd100; bet = 11'd5; rnd = 9'o444;
    push(0, 0, 0, 0, 0, 0, 0);
    push(1, 0, JP, 2'b10, 4, 4, 4);
    gamble = 1'b1; cyc(); gamble = 1'b0;
    do_tick();
    do_tick();
    rnd = 9'o000;
    cash_out = 1'b1;
    cyc();
    cash_out = 1'b0;
    cmp("abort_run", int'(reel_run), 0);
    cmp("abort_busy", int'(busy), 0);
    cyc(3);

    // staggered stops, balance equal to bet, no win
    balance = 11'd10; bet = 11'd10;
    push(0, 0, 0, 0, 0, 0, 0);
    push(1, 0, 11'd0, 2'b00, 1, 2, 3);
    gamble = 1'b1; cyc(); gamble = 1'b0;
    rnd = 9'o123; do_tick();
    cmp("run_t1", int'(reel_run), 7);
    rnd = 9'o456; do_tick();
    cmp("run_t2", int'(reel_run), 7);
    rnd = 9'o001; do_tick();
    cmp("run_t3", int'(reel_run), 6);
    rnd = 9'o020; do_tick();
    cmp("run_t4", int'(reel_run), 4);
    rnd = 9'o321;
    tick = 1'b1; cyc(); tick = 1'b0;
    cmp("run_t5", int'(reel_run), 0);
    cmp("eval_busy", int'(busy), 1);
    cyc(4);

    // gamble with cash_out in idle
    balance = 11'd100; bet = 11'd10;
    gamble = 1'b1; cash_out = 1'b1; cyc();
    gamble = 1'b0; cash_out = 1'b0; cyc(3);
    cmp("both_busy", int'(busy), 0);

    // asynchronous reset in the middle of a spin
    push(0, 0, 0, 0, 0, 0, 0);
    push(1, 0, 11'd0, 2'b00, 0, 0, 0);
    rnd = 9'o765;
    gamble = 1'b1; cyc(); gamble = 1'b0;
    do_tick();
    rst_n = 1'b0;
    #1;
    cmp("mid_rst_busy", int'(busy), 0);
    cmp("mid_rst_run", int'(reel_run), 0);
    cmp("mid_rst_debit", int'(debit), 0);
    cmp("mid_rst_credit", int'(credit), 0);
    cmp("mid_rst_payout", int'(payout), 0);
    cmp("mid_rst_result", int'(result), 0);
    cmp("mid_rst_digit", int'(digit_1), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(3);

    cmp("queue_left", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
